// File: rtl/argmax_ctrl_fix4_if.sv
// Control/result bundle between the argmax sequencer, the inference engine and the result consumer.
// slave is the sequencer's view; master is the view of whatever drives it.
interface argmax_ctrl_fix4_if #(
  parameter int DATA_WIDTH = 4,
  parameter int IDX_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                         req;
  logic                         busy;
  logic                         eng_reset;
  logic                         eng_start;
  logic                         eng_done;
  logic [IDX_WIDTH-1:0]         out_idx;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         res_valid;
  logic                         res_ready;
  logic [IDX_WIDTH-1:0]         res_class;
  logic signed [DATA_WIDTH-1:0] res_max;
  logic [DATA_WIDTH:0]          res_margin;
  logic [CNT_WIDTH-1:0]         res_cycles;

  modport slave (
    input  req, eng_done, out_data, res_ready,
    output busy, eng_reset, eng_start, out_idx,
    output res_valid, res_class, res_max, res_margin, res_cycles
  );

  modport master (
    output req, eng_done, out_data, res_ready,
    input  busy, eng_reset, eng_start, out_idx,
    input  res_valid, res_class, res_max, res_margin, res_cycles
  );
endinterface

// File: rtl/argmax_ctrl_fix4.sv
// Resets/starts the engine, times it, sweeps its class scores and reports argmax, max, top-2 margin.
// Result appears NUM_CLASSES+1 cycles after eng_done; res_valid holds until res_ready, req ignored while busy.
module argmax_ctrl_fix4 #(
  parameter int DATA_WIDTH  = 4,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  argmax_ctrl_fix4_if.slave ctl
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_ENG,
    S_START,
    S_WAIT,
    S_SCAN,
    S_RESULT
  } state_t;

  localparam logic [IDX_WIDTH-1:0]         LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]         CNT_MAX   = {CNT_WIDTH{1'b1}};

  state_t                       state_q, state_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic signed [DATA_WIDTH-1:0] sec_q, sec_d;
  logic [IDX_WIDTH-1:0]         cls_q, cls_d;
  logic [IDX_WIDTH-1:0]         idx_q, idx_d;
  logic [IDX_WIDTH-1:0]         res_class_q, res_class_d;
  logic signed [DATA_WIDTH-1:0] res_max_q, res_max_d;
  logic [DATA_WIDTH:0]          res_margin_q, res_margin_d;
  logic [CNT_WIDTH-1:0]         res_cycles_q, res_cycles_d;

  logic                         busy, eng_reset, eng_start, res_valid;
  logic signed [DATA_WIDTH-1:0] data;

  assign data = ctl.out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      max_q        <= '0;
      sec_q        <= '0;
      cls_q        <= '0;
      idx_q        <= '0;
      res_class_q  <= '0;
      res_max_q    <= '0;
      res_margin_q <= '0;
      res_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      max_q        <= max_d;
      sec_q        <= sec_d;
      cls_q        <= cls_d;
      idx_q        <= idx_d;
      res_class_q  <= res_class_d;
      res_max_q    <= res_max_d;
      res_margin_q <= res_margin_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    max_d        = max_q;
    sec_d        = sec_q;
    cls_d        = cls_q;
    idx_d        = idx_q;
    res_class_d  = res_class_q;
    res_max_d    = res_max_q;
    res_margin_d = res_margin_q;
    res_cycles_d = res_cycles_q;
    busy         = (state_q != S_IDLE);
    eng_reset    = 1'b0;
    eng_start    = 1'b0;
    res_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctl.req) state_d = S_RST_ENG;
      end
      S_RST_ENG: begin
        eng_reset = 1'b1;
        state_d   = S_START;
      end
      S_START: begin
        eng_start = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (ctl.eng_done) begin
          res_cycles_d = cnt_q;
          idx_d        = '0;
          state_d      = S_SCAN;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lowest index on ties; the tied score becomes second.
        if (idx_q == '0) begin
          max_d = data;
          sec_d = MIN_SCORE;
          cls_d = '0;
        end else if (data > max_q) begin
          sec_d = max_q;
          max_d = data;
          cls_d = idx_q;
        end else if (data > sec_q) begin
          sec_d = data;
        end

        if (idx_q == LAST_IDX) begin
          res_class_d  = cls_d;
          res_max_d    = max_d;
          res_margin_d = {max_d[DATA_WIDTH-1], max_d} - {sec_d[DATA_WIDTH-1], sec_d};
          idx_d        = '0;
          state_d      = S_RESULT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (ctl.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ctl.busy       = busy;
  assign ctl.eng_reset  = eng_reset;
  assign ctl.eng_start  = eng_start;
  assign ctl.out_idx    = idx_q;
  assign ctl.res_valid  = res_valid;
  assign ctl.res_class  = res_class_q;
  assign ctl.res_max    = res_max_q;
  assign ctl.res_margin = res_margin_q;
  assign ctl.res_cycles = res_cycles_q;

endmodule
